// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its issue stage:
// opcode width, issue-stage FSM encoding and settle-counter width.
package alu_pkg;

  // Opcode width used by the ALU and every block that drives it.
  localparam int OP_WIDTH = 4;

  // Width of the settle counter; holds the largest legal SETTLE_CYCLES (15).
  localparam int SETTLE_CNT_WIDTH = 4;

  // Issue-stage sequencing: wait for a command, let the ALU settle,
  // then hold the captured result until downstream takes it.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } alu_issue_state_e;

endpackage : alu_pkg

// File: rtl/alu_issue_if.sv
// Bundle of the issue stage's command/result handshakes plus the ALU
// operand/result wires, so a bench can drive and observe one stage
// through a single handle. Optional counters appear when
// ALU_ISSUE_STATS_EN is defined.
interface alu_issue_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  localparam int OUT_WIDTH = DATA_WIDTH * 2;

  // Command side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [OP_WIDTH-1:0]   cmd_op;

  // ALU side
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [OP_WIDTH-1:0]   alu_op;
  logic [OUT_WIDTH-1:0]  alu_out;

  // Result side
  logic                  res_valid;
  logic                  res_ready;
  logic [OUT_WIDTH-1:0]  res_data;
  logic [OP_WIDTH-1:0]   res_op;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]           txn_count;
  logic [15:0]           stall_count;
`endif

  // View from the issue stage itself
  modport stage (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op
`ifdef ALU_ISSUE_STATS_EN
    , output txn_count, stall_count
`endif
  );

  // View from whoever issues commands and consumes results
  modport driver (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_out, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_op
`ifdef ALU_ISSUE_STATS_EN
    , input txn_count, stall_count
`endif
  );

endinterface : alu_issue_if

// File: rtl/alu_issue_stage.sv
// Upstream sequencer for the combinational ALU. Accepts one command at a
// time, drives the ALU operands from registers, waits for the datapath to
// settle, captures the result and hands it downstream over valid/ready.
// Optional feature macro: ALU_ISSUE_STATS_EN adds txn_count/stall_count.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH    = 8,
  parameter  int SETTLE_CYCLES = 1,   // legal range 1..15
  localparam int OUT_WIDTH     = DATA_WIDTH * 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Command handshake
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [OP_WIDTH-1:0]   cmd_op,
  // ALU datapath
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [OUT_WIDTH-1:0]  alu_out,
  // Result handshake
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OUT_WIDTH-1:0]  res_data,
  output logic [OP_WIDTH-1:0]   res_op
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]           txn_count,
  output logic [15:0]           stall_count
`endif
);

  // The operand registers take one edge to present a new command to the
  // ALU; after that the datapath gets SETTLE_CYCLES full cycles before the
  // capture edge. Counting down from SETTLE_CYCLES to zero places the
  // capture SETTLE_CYCLES+1 edges after the accept edge.
  localparam logic [SETTLE_CNT_WIDTH-1:0] SETTLE_LOAD =
    SETTLE_CNT_WIDTH'(SETTLE_CYCLES);

  alu_issue_state_e              state_q, state_d;
  logic [SETTLE_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                          cmd_ready_q, cmd_ready_d;
  logic                          res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0]         alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]         alu_b_q, alu_b_d;
  logic [OP_WIDTH-1:0]           alu_op_q, alu_op_d;
  logic [OUT_WIDTH-1:0]          res_data_q, res_data_d;
  logic [OP_WIDTH-1:0]           res_op_q, res_op_d;

  logic                          cmd_accept;
  logic                          res_accept;

  // Handshake qualifiers; cmd_ready is only ever high in IDLE and
  // res_valid only in HOLD, so these also imply the current state.
  assign cmd_accept = cmd_valid & cmd_ready_q;
  assign res_accept = res_valid_q & res_ready;

  // Next-state and datapath-register update for the issue FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          // Capture edge: the only point at which alu_out is sampled.
          res_data_d  = alu_out;
          res_op_d    = alu_op_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - SETTLE_CNT_WIDTH'(1);
        end
      end

      HOLD: begin
        if (res_accept) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    // Registered ready: high exactly in the cycles the FSM sits in IDLE.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop here has a reset value because reset must leave the
    // ALU ports and result outputs at zero, not just the FSM idle.
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign res_valid = res_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Transaction count wraps; stall count saturates at all-ones.
  always_comb begin
    txn_count_d   = txn_count_q;
    stall_count_d = stall_count_q;
    if (res_accept) begin
      txn_count_d = txn_count_q + 16'd1;
    end
    if ((state_q == HOLD) && !res_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      txn_count_q   <= txn_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign txn_count   = txn_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule : alu_issue_stage

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: one instance with SETTLE_CYCLES=1
// and one with SETTLE_CYCLES=4, each reached through an alu_issue_if.
// Counter checks run when ALU_ISSUE_STATS_EN is defined.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst4_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.DATA_WIDTH(8)) i1 ();
  alu_issue_if #(.DATA_WIDTH(8)) i4 ();

  alu_issue_stage #(.DATA_WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .cmd_valid (i1.cmd_valid),
    .cmd_ready (i1.cmd_ready),
    .cmd_a     (i1.cmd_a),
    .cmd_b     (i1.cmd_b),
    .cmd_op    (i1.cmd_op),
    .alu_a     (i1.alu_a),
    .alu_b     (i1.alu_b),
    .alu_op    (i1.alu_op),
    .alu_out   (i1.alu_out),
    .res_valid (i1.res_valid),
    .res_ready (i1.res_ready),
    .res_data  (i1.res_data),
    .res_op    (i1.res_op)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .txn_count   (i1.txn_count),
    .stall_count (i1.stall_count)
`endif
  );

  alu_issue_stage #(.DATA_WIDTH(8), .SETTLE_CYCLES(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst4_n),
    .cmd_valid (i4.cmd_valid),
    .cmd_ready (i4.cmd_ready),
    .cmd_a     (i4.cmd_a),
    .cmd_b     (i4.cmd_b),
    .cmd_op    (i4.cmd_op),
    .alu_a     (i4.alu_a),
    .alu_b     (i4.alu_b),
    .alu_op    (i4.alu_op),
    .alu_out   (i4.alu_out),
    .res_valid (i4.res_valid),
    .res_ready (i4.res_ready),
    .res_data  (i4.res_data),
    .res_op    (i4.res_op)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .txn_count   (i4.txn_count),
    .stall_count (i4.stall_count)
`endif
  );

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    i1.cmd_valid = 1'b0; i1.cmd_a = '0; i1.cmd_b = '0; i1.cmd_op = '0;
    i1.alu_out = '0;     i1.res_ready = 1'b1;
    i4.cmd_valid = 1'b0; i4.cmd_a = '0; i4.cmd_b = '0; i4.cmd_op = '0;
    i4.alu_out = '0;     i4.res_ready = 1'b1;
    repeat (3) tick;
    checks++;
    if (i1.cmd_ready !== 1'b0 || i1.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: cmd_ready=%b res_valid=%b expected 0 0", i1.cmd_ready, i1.res_valid);
    end
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    tick;
    checks++;
    if (i1.cmd_ready !== 1'b1 || i4.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready1=%b cmd_ready4=%b expected 1 1", i1.cmd_ready, i4.cmd_ready);
    end
    checks++;
    if (i1.res_valid !== 1'b0 || i1.alu_a !== 8'h00 || i1.alu_b !== 8'h00 || i1.alu_op !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: res_valid=%b a=%h b=%h op=%h expected 0 00 00 0",
               i1.res_valid, i1.alu_a, i1.alu_b, i1.alu_op);
    end
  endtask

  task automatic test_single;
    int lat = 0;
    i1.res_ready = 1'b1;
    i1.alu_out   = 16'h0012;
    i1.cmd_a = 8'h0F; i1.cmd_b = 8'h03; i1.cmd_op = 4'h0; i1.cmd_valid = 1'b1;
    tick;  // accept edge
    i1.cmd_valid = 1'b0;
    checks++;
    if (i1.alu_a !== 8'h0F || i1.alu_b !== 8'h03 || i1.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_latch: a=%h b=%h cmd_ready=%b expected 0f 03 0", i1.alu_a, i1.alu_b, i1.cmd_ready);
    end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick;
      if (i1.res_valid === 1'b1) lat = c;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles expected 2", lat);
    end
    checks++;
    if (i1.res_data !== 16'h0012 || i1.res_op !== 4'h0) begin
      errors++;
      $display("FAIL single_data: data=%h op=%h expected 0012 0", i1.res_data, i1.res_op);
    end
    tick;  // handshake edge
    checks++;
    if (i1.res_valid !== 1'b0 || i1.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_return: res_valid=%b cmd_ready=%b expected 0 1", i1.res_valid, i1.cmd_ready);
    end
  endtask

  task automatic test_stall;
    bit seen = 1'b0;
    int bad = 0;
    i1.res_ready = 1'b0;
    i1.alu_out   = 16'h0035;
    i1.cmd_a = 8'h25; i1.cmd_b = 8'h10; i1.cmd_op = 4'h3; i1.cmd_valid = 1'b1;
    tick;
    i1.cmd_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick;
      if (i1.res_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_wait: res_valid not seen within 20 cycles");
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 2) i1.alu_out = 16'hBEEF;
      if (c == 4) begin
        i1.cmd_a = 8'hFF; i1.cmd_b = 8'hEE; i1.cmd_op = 4'h7; i1.cmd_valid = 1'b1;
      end
      if (c == 5) i1.cmd_valid = 1'b0;
      tick;
      if (i1.res_data !== 16'h0035 || i1.cmd_ready !== 1'b0 || i1.res_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d bad cycles, last data=%h cmd_ready=%b res_valid=%b expected 0035 0 1",
               bad, i1.res_data, i1.cmd_ready, i1.res_valid);
    end
    checks++;
    if (i1.alu_a !== 8'h25 || i1.res_op !== 4'h3) begin
      errors++;
      $display("FAIL stall_ignore_cmd: alu_a=%h res_op=%h expected 25 3", i1.alu_a, i1.res_op);
    end
    i1.res_ready = 1'b1;
    tick;
    checks++;
    if (i1.cmd_ready !== 1'b1 || i1.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: cmd_ready=%b res_valid=%b expected 1 0", i1.cmd_ready, i1.res_valid);
    end
  endtask

  task automatic test_settle4;
    int lat = 0;
    i4.res_ready = 1'b1;
    i4.alu_out   = 16'hAAAA;
    i4.cmd_a = 8'h12; i4.cmd_b = 8'h34; i4.cmd_op = 4'h1; i4.cmd_valid = 1'b1;
    tick;
    i4.cmd_valid = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick;
      if (c == 2) i4.alu_out = 16'h5555;
      if (i4.res_valid === 1'b1) lat = c;
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL settle4_latency: got %0d cycles expected 5", lat);
    end
    checks++;
    if (i4.res_data !== 16'h5555 || i4.res_op !== 4'h1) begin
      errors++;
      $display("FAIL settle4_data: data=%h op=%h expected 5555 1", i4.res_data, i4.res_op);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    bit rose = 1'b0;
    int lat = 0;
    i4.res_ready = 1'b1;
    i4.alu_out   = 16'h0003;
    i4.cmd_a = 8'h01; i4.cmd_b = 8'h02; i4.cmd_op = 4'h2; i4.cmd_valid = 1'b1;
    tick;
    i4.cmd_valid = 1'b0;
    tick;
    rst4_n = 1'b0;
    #1;
    checks++;
    if (i4.cmd_ready !== 1'b0 || i4.res_valid !== 1'b0 || i4.alu_a !== 8'h00 || i4.alu_op !== 4'h0) begin
      errors++;
      $display("FAIL midreset_async: cmd_ready=%b res_valid=%b a=%h op=%h expected 0 0 00 0",
               i4.cmd_ready, i4.res_valid, i4.alu_a, i4.alu_op);
    end
    repeat (2) tick;
    rst4_n = 1'b1;
    tick;
    checks++;
    if (i4.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_idle: cmd_ready=%b expected 1", i4.cmd_ready);
    end
    for (int c = 0; c < 8; c++) begin
      if (i4.res_valid !== 1'b0) rose = 1'b1;
      tick;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL midreset_no_result: res_valid rose=1 expected 0");
    end
    i4.alu_out = 16'h000F;
    i4.cmd_a = 8'h07; i4.cmd_b = 8'h08; i4.cmd_op = 4'h5; i4.cmd_valid = 1'b1;
    tick;
    i4.cmd_valid = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick;
      if (i4.res_valid === 1'b1) lat = c;
    end
    checks++;
    if (lat != 5 || i4.res_data !== 16'h000F || i4.res_op !== 4'h5) begin
      errors++;
      $display("FAIL midreset_next: latency=%0d data=%h op=%h expected 5 000f 5", lat, i4.res_data, i4.res_op);
    end
    tick;
  endtask

`ifdef ALU_ISSUE_STATS_EN
  task automatic test_stats;
    rst1_n = 1'b0;
    #1;
    tick;
    rst1_n = 1'b1;
    tick;
    checks++;
    if (i1.txn_count !== 16'd0 || i1.stall_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: txn=%0d stall=%0d expected 0 0", i1.txn_count, i1.stall_count);
    end
    for (int t = 0; t < 3; t++) begin
      int stall = (t == 1) ? 4 : 0;
      bit seen = 1'b0;
      logic [15:0] exp_data = 16'h0100 + 16'(t);
      i1.res_ready = (stall == 0);
      i1.alu_out   = exp_data;
      i1.cmd_a = 8'(t + 1); i1.cmd_b = 8'h40; i1.cmd_op = 4'(t); i1.cmd_valid = 1'b1;
      tick;
      i1.cmd_valid = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        tick;
        if (i1.res_valid === 1'b1) seen = 1'b1;
      end
      repeat (stall) tick;
      i1.res_ready = 1'b1;
      checks++;
      if (!seen || i1.res_data !== exp_data) begin
        errors++;
        $display("FAIL stats_txn%0d_data: seen=%b data=%h expected 1 %h", t, seen, i1.res_data, exp_data);
      end
      tick;
      checks++;
      if (i1.txn_count !== 16'(t + 1)) begin
        errors++;
        $display("FAIL stats_txn%0d_count: txn=%0d expected %0d", t, i1.txn_count, t + 1);
      end
    end
    checks++;
    if (i1.stall_count !== 16'd4) begin
      errors++;
      $display("FAIL stats_stall: stall=%0d expected 4", i1.stall_count);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_settle4;
    test_reset_mid;
`ifdef ALU_ISSUE_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_issue_stage
